kws_eval_sequencer: RTL and testbench

Hardware campaign driver for the Q8.8 keyword-spotting classifier core: the initiator side of its start/sample_index → predicted_class/valid handshake. It sequences every stored sample through the core, compares each prediction against an internal expected-label ROM, and reports the pass count, per-sample mismatches and timeout errors. It sits beside the classifier in on-board self-test builds, replacing the simulation bench with synthesizable logic.

---
 rtl/kws_eval_sequencer.sv | 93 +++++++++
 tb/tb_kws_eval_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/kws_eval_sequencer.sv
// kws_eval_sequencer: runs every stored sample through the classifier and scores predictions against a label ROM
module kws_eval_sequencer #(
   parameter int NUM_SAMPLES = 10,
   parameter int IDX_W = 4,
   parameter int CLASS_W = 4,
   parameter logic [NUM_SAMPLES*CLASS_W-1:0] EXPECTED_LABELS = 40'h2844585284,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int GAP_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   output logic                   nn_start,
   output logic [IDX_W-1:0]       nn_sample_index,
   input  logic [CLASS_W-1:0]     nn_predicted_class,
   input  logic                   nn_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err,
   output logic [4:0]             pass_count,
   output logic [NUM_SAMPLES-1:0] mismatch_mask,
   output logic [CLASS_W-1:0]     last_class
);
   localparam int CNT_W = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
   typedef enum logic [2:0] {IDLE, START, WAIT_VALID, WAIT_LOW, GAP, DONE} state_t;
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic [CLASS_W-1:0] exp_label;
   logic hit, last_sample;
   assign exp_label = CLASS_W'(EXPECTED_LABELS >> (32'(nn_sample_index) * CLASS_W));
   assign hit = nn_predicted_class == exp_label;
   assign last_sample = nn_sample_index == IDX_W'(NUM_SAMPLES - 1);
   // campaign sequencer; the shared counter times WAIT_VALID and then the inter-sample gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         nn_start <= 1'b0;
         nn_sample_index <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         timeout_err <= 1'b0;
         pass_count <= '0;
         mismatch_mask <= '0;
         last_class <= '0;
      end else begin
         nn_start <= 1'b0;
         case (state)
            IDLE, DONE: if (run && !nn_valid) begin
               state <= START;
               nn_start <= 1'b1;
               busy <= 1'b1;
               done <= 1'b0;
               timeout_err <= 1'b0;
               pass_count <= '0;
               mismatch_mask <= '0;
               nn_sample_index <= '0;
            end
            START: begin
               cnt <= '0;
               state <= WAIT_VALID;
            end
            WAIT_VALID: if (nn_valid) begin
               last_class <= nn_predicted_class;
               if (hit) pass_count <= pass_count + 5'd1;
               else mismatch_mask[nn_sample_index] <= 1'b1;
               state <= WAIT_LOW;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_err <= 1'b1;
               done <= 1'b1;
               busy <= 1'b0;
               state <= DONE;
            end else cnt <= (&cnt) ? cnt : cnt + 1'b1;
            WAIT_LOW: if (!nn_valid) begin
               cnt <= '0;
               state <= GAP;
            end
            GAP: if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
               if (last_sample) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  state <= DONE;
               end else begin
                  nn_sample_index <= nn_sample_index + 1'b1;
                  nn_start <= 1'b1;
                  state <= START;
               end
            end else cnt <= cnt + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kws_eval_sequencer.sv
// tb_kws_eval_sequencer: scoreboard bench with a behavioural classifier model around the sequencer
module tb_kws_eval_sequencer;
   logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, nn_valid = 1'b0;
   logic [3:0] nn_predicted_class = '0;
   logic nn_start, busy, done, timeout_err;
   logic [3:0] nn_sample_index, last_class;
   logic [4:0] pass_count;
   logic [9:0] mismatch_mask;
   typedef struct packed {logic [4:0] pass; logic [9:0] mask; logic to; logic [3:0] last;} res_t;
   int tests = 0, fails = 0;
   int latency = 20, hold = 1, silent_idx = 99;
   logic [3:0] resp [16];
   logic [3:0] start_q [$];
   res_t res_q [$];
   logic [3:0] labels [10] = '{4'd4, 4'd8, 4'd2, 4'd5, 4'd8, 4'd5, 4'd4, 4'd4, 4'd8, 4'd2};

   kws_eval_sequencer #(.TIMEOUT_CYCLES(50)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .nn_start(nn_start), .nn_sample_index(nn_sample_index),
      .nn_predicted_class(nn_predicted_class), .nn_valid(nn_valid), .busy(busy), .done(done),
      .timeout_err(timeout_err), .pass_count(pass_count), .mismatch_mask(mismatch_mask), .last_class(last_class));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // classifier model: answers each start after latency cycles, holds valid for hold cycles
   initial begin
      int idx;
      forever begin
         @(posedge clk);
         #1;
         if (nn_start && rst_n) begin
            idx = int'(nn_sample_index);
            if (idx != silent_idx) begin
               repeat (latency) @(posedge clk);
               #1 nn_valid = 1'b1;
               nn_predicted_class = resp[idx];
               repeat (hold) @(posedge clk);
               #1 nn_valid = 1'b0;
            end
         end
      end
   end

   // monitor: checks every start pulse and every campaign result against the queues
   initial begin
      logic done_d = 1'b0;
      res_t r;
      forever begin
         @(negedge clk);
         if (nn_start) begin
            if (start_q.size() == 0) check("unexpected_start", 32'(nn_sample_index), 32'hFFFF);
            else check("start_idx", 32'(nn_sample_index), 32'(start_q.pop_front()));
         end
         if (done && !done_d) begin
            if (res_q.size() == 0) check("unexpected_done", 32'(done), 32'hFFFF);
            else begin
               r = res_q.pop_front();
               check("res_pass", 32'(pass_count), 32'(r.pass));
               check("res_mask", 32'(mismatch_mask), 32'(r.mask));
               check("res_timeout", 32'(timeout_err), 32'(r.to));
               check("res_last", 32'(last_class), 32'(r.last));
               check("res_busy", 32'(busy), 32'd0);
            end
         end
         done_d = done;
      end
   end

   task automatic set_ideal();
      for (int i = 0; i < 16; i++) resp[i] = i < 10 ? labels[i] : 4'd0;
   endtask

   task automatic push_starts(input int n);
      for (int i = 0; i < n; i++) start_q.push_back(4'(i));
   endtask

   task automatic pulse_run();
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic wait_start(input int idx);
      int n = 0;
      while (!(nn_start && nn_sample_index == 4'(idx)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", 32'(nn_start), 32'd1);
   endtask

   initial begin
      int n;
      set_ideal();
      repeat (2) @(negedge clk);
      check("rst_start", 32'(nn_start), 0);
      check("rst_idx", 32'(nn_sample_index), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_to", 32'(timeout_err), 0);
      check("rst_pass", 32'(pass_count), 0);
      check("rst_mask", 32'(mismatch_mask), 0);
      check("rst_last", 32'(last_class), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_busy", 32'(busy), 0);

      // ideal campaign
      push_starts(10);
      res_q.push_back('{5'd10, 10'd0, 1'b0, 4'd2});
      pulse_run();
      check("t1_busy_after_run", 32'(busy), 1);
      wait_done("t1_done");
      repeat (5) @(negedge clk);

      // two mispredictions
      resp[2] = 4'd8;
      resp[3] = 4'd4;
      push_starts(10);
      res_q.push_back('{5'd8, 10'b0000001100, 1'b0, 4'd2});
      pulse_run();
      wait_done("t2_done");
      repeat (5) @(negedge clk);

      // sample 4 never answers
      set_ideal();
      silent_idx = 4;
      push_starts(5);
      res_q.push_back('{5'd4, 10'd0, 1'b1, 4'd5});
      pulse_run();
      wait_start(4);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t3_timeout_latency", 32'(n), 32'd51);
      repeat (100) @(negedge clk);
      check("t3_to_held", 32'(timeout_err), 1);
      check("t3_idle_busy", 32'(busy), 0);
      silent_idx = 99;

      // valid held for 30 cycles
      hold = 30;
      push_starts(10);
      res_q.push_back('{5'd10, 10'd0, 1'b0, 4'd2});
      pulse_run();
      n = 0;
      while (!nn_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      while (nn_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!nn_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t4_gap", 32'(n), 32'd3);
      wait_done("t4_done");
      hold = 1;
      repeat (5) @(negedge clk);

      // run during campaign ignored, then rerun clears results
      resp[0] = 4'd0;
      push_starts(10);
      res_q.push_back('{5'd9, 10'b0000000001, 1'b0, 4'd2});
      pulse_run();
      wait_start(5);
      pulse_run();
      check("t5_busy_kept", 32'(busy), 1);
      wait_done("t5_done_a");
      repeat (5) @(negedge clk);
      set_ideal();
      push_starts(10);
      res_q.push_back('{5'd10, 10'd0, 1'b0, 4'd2});
      pulse_run();
      check("t5_pass_cleared", 32'(pass_count), 0);
      check("t5_mask_cleared", 32'(mismatch_mask), 0);
      check("t5_done_cleared", 32'(done), 0);
      wait_done("t5_done_b");
      repeat (5) @(negedge clk);

      // reset during WAIT_VALID of sample 6
      push_starts(10);
      res_q.push_back('{5'd10, 10'd0, 1'b0, 4'd2});
      pulse_run();
      wait_start(6);
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t6_start", 32'(nn_start), 0);
      check("t6_idx", 32'(nn_sample_index), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_pass", 32'(pass_count), 0);
      check("t6_last", 32'(last_class), 0);
      start_q.delete();
      res_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      push_starts(10);
      res_q.push_back('{5'd10, 10'd0, 1'b0, 4'd2});
      pulse_run();
      wait_done("t6_done");
      repeat (5) @(negedge clk);
      check("start_q_empty", 32'(start_q.size()), 0);
      check("res_q_empty", 32'(res_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
